// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock activity monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ABSENT     = 2'd0,
    QUALIFYING = 2'd1,
    PRESENT    = 2'd2,
    LOSING     = 2'd3
  } ch_state_e;

  localparam int unsigned DEF_NUM_CLKS      = 2;
  localparam int unsigned DEF_WINDOW_CYCLES = 100;
  localparam int unsigned DEF_MIN_EDGES     = 20;
  localparam int unsigned DEF_MAX_EDGES     = 60;
  localparam int unsigned DEF_ACQ_WINDOWS   = 2;
  localparam int unsigned DEF_LOSS_WINDOWS  = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_mon_channel.sv
// One monitored clock: synchronizer, edge counter, window compare and presence FSM.
// Optional CLK_MON_FREQ_REPORT_EN adds the per-window edge count output.
module clk_mon_channel
  import clk_mon_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned MIN_EDGES     = DEF_MIN_EDGES,
  parameter int unsigned MAX_EDGES     = DEF_MAX_EDGES,
  parameter int unsigned ACQ_WINDOWS   = DEF_ACQ_WINDOWS,
  parameter int unsigned LOSS_WINDOWS  = DEF_LOSS_WINDOWS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic window_end,
  input  logic toggle,
  output logic present,
  output logic present_nxt_c
`ifdef CLK_MON_FREQ_REPORT_EN
  , output logic [15:0] freq_count
`endif
);

  localparam int unsigned CNT_W   = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned RUN_MAX = max_u(ACQ_WINDOWS, LOSS_WINDOWS);
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  logic             sync1, sync2, sync3;
  logic             edge_hit;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             good;
  ch_state_e        state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;

  // Synchronizer plus delay flop; restart deliberately leaves these alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= toggle;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_hit = sync2 ^ sync3;
  // Includes the edge of the current cycle so a window_end edge lands in the closing window.
  assign cnt_inc  = (cnt == CNT_W'(WINDOW_CYCLES)) ? cnt : CNT_W'(cnt + CNT_W'(edge_hit));
  assign good     = (cnt_inc >= CNT_W'(MIN_EDGES)) && (cnt_inc <= CNT_W'(MAX_EDGES));
  assign run_inc  = RUN_W'(run + RUN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || window_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ABSENT;
      run     <= '0;
      present <= 1'b0;
    end else begin
      state   <= state_nxt;
      run     <= run_nxt;
      present <= present_nxt_c;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (restart) begin
      state_nxt = ABSENT;
      run_nxt   = '0;
    end else if (window_end) begin
      unique case (state)
        ABSENT: begin
          if (good) begin
            if (ACQ_WINDOWS == 1) begin
              state_nxt = PRESENT;
            end else begin
              state_nxt = QUALIFYING;
              run_nxt   = RUN_W'(1);
            end
          end
        end
        QUALIFYING: begin
          if (!good) begin
            state_nxt = ABSENT;
            run_nxt   = '0;
          end else if (run_inc >= RUN_W'(ACQ_WINDOWS)) begin
            state_nxt = PRESENT;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc;
          end
        end
        PRESENT: begin
          if (!good) begin
            if (LOSS_WINDOWS == 1) begin
              state_nxt = ABSENT;
            end else begin
              state_nxt = LOSING;
              run_nxt   = RUN_W'(1);
            end
          end
        end
        LOSING: begin
          if (good) begin
            state_nxt = PRESENT;
            run_nxt   = '0;
          end else if (run_inc >= RUN_W'(LOSS_WINDOWS)) begin
            state_nxt = ABSENT;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc;
          end
        end
        default: begin
          state_nxt = ABSENT;
          run_nxt   = '0;
        end
      endcase
    end
    present_nxt_c = (state_nxt == PRESENT) || (state_nxt == LOSING);
  end

`ifdef CLK_MON_FREQ_REPORT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_count <= '0;
    end else if (restart) begin
      freq_count <= '0;
    end else if (window_end) begin
      freq_count <= 16'(cnt_inc);
    end
  end
`endif

endmodule

// File: rtl/clk_activity_monitor.sv
// Clock presence monitor: shared window timer, per-clock channels, priority select.
// Optional CLK_MON_FREQ_REPORT_EN exposes freq_count.
module clk_activity_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned NUM_CLKS      = DEF_NUM_CLKS,
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned MIN_EDGES     = DEF_MIN_EDGES,
  parameter int unsigned MAX_EDGES     = DEF_MAX_EDGES,
  parameter int unsigned ACQ_WINDOWS   = DEF_ACQ_WINDOWS,
  parameter int unsigned LOSS_WINDOWS  = DEF_LOSS_WINDOWS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic [NUM_CLKS-1:0] mon_toggle,
  output logic [NUM_CLKS-1:0] clk_present,
  output logic                any_present,
  output logic                sel_valid,
  output logic [((NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1)-1:0] sel_idx,
  output logic                status_change,
  output logic                window_end
`ifdef CLK_MON_FREQ_REPORT_EN
  , output logic [NUM_CLKS*16-1:0] freq_count
`endif
);

  localparam int unsigned SEL_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;
  localparam int unsigned TMR_W = $clog2(WINDOW_CYCLES);

  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [NUM_CLKS-1:0] present_nxt;

  always_comb begin
    timer_nxt = TMR_W'(timer + TMR_W'(1));
    if (restart || (timer == TMR_W'(WINDOW_CYCLES - 1))) begin
      timer_nxt = '0;
    end
  end

  // window_end is registered from the next timer value so it tracks timer == last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer         <= '0;
      window_end    <= 1'b0;
      status_change <= 1'b0;
    end else begin
      timer         <= timer_nxt;
      window_end    <= (timer_nxt == TMR_W'(WINDOW_CYCLES - 1));
      status_change <= |(present_nxt ^ clk_present);
    end
  end

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_ch
    clk_mon_channel #(
      .WINDOW_CYCLES(WINDOW_CYCLES),
      .MIN_EDGES    (MIN_EDGES),
      .MAX_EDGES    (MAX_EDGES),
      .ACQ_WINDOWS  (ACQ_WINDOWS),
      .LOSS_WINDOWS (LOSS_WINDOWS)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .restart      (restart),
      .window_end   (window_end),
      .toggle       (mon_toggle[g]),
      .present      (clk_present[g]),
      .present_nxt_c(present_nxt[g])
`ifdef CLK_MON_FREQ_REPORT_EN
      , .freq_count (freq_count[g*16 +: 16])
`endif
    );
  end

  assign any_present = |clk_present;
  assign sel_valid   = any_present;

  // Lowest present index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CLKS - 1; i >= 0; i--) begin
      if (clk_present[i]) sel_idx = SEL_W'(i);
    end
  end

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Self-checking bench for clk_activity_monitor: table rows, corner sequences, random windows.
module tb_clk_activity_monitor;

  localparam int W    = 100;
  localparam int MINE = 20;
  localparam int MAXE = 60;
  localparam int ACQ  = 2;
  localparam int LOSS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] mon_toggle = 2'b00;
  logic [1:0] clk_present;
  logic       any_present, sel_valid, status_change, window_end;
  logic [0:0] sel_idx;
`ifdef CLK_MON_FREQ_REPORT_EN
  logic [31:0] freq_count;
`endif

  clk_activity_monitor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      (restart),
    .mon_toggle   (mon_toggle),
    .clk_present  (clk_present),
    .any_present  (any_present),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .status_change(status_change),
    .window_end   (window_end)
`ifdef CLK_MON_FREQ_REPORT_EN
    , .freq_count (freq_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: window position, input history, counts, consecutive good/bad runs.
  int       t;
  logic [2:0] hist[2];
  int       cnt[2];
  bit       mp[2];
  int       gr[2];
  int       br[2];
  int       lastc[2];
  bit       chg;

  int per[2];
  int ph[2];

  typedef struct {
    int         per0;
    int         per1;
    int         nwin;
    logic [1:0] exp_present;
    logic       exp_idx;
  } row_t;
  row_t rows[7];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    chg = 0;
    for (int ch = 0; ch < 2; ch++) begin
      hist[ch] = 3'b000; cnt[ch] = 0; mp[ch] = 0;
      gr[ch] = 0; br[ch] = 0; lastc[ch] = 0;
    end
  endtask

  task automatic model_edge(input logic [1:0] tog, input bit rs);
    bit oldp[2];
    int c;
    bit good;
    for (int ch = 0; ch < 2; ch++) begin
      oldp[ch] = mp[ch];
      c = cnt[ch] + int'(hist[ch][1] ^ hist[ch][2]);
      if (c > W) c = W;
      if (rs) begin
        cnt[ch] = 0; mp[ch] = 0; gr[ch] = 0; br[ch] = 0; lastc[ch] = 0;
      end else if (t == W - 1) begin
        good = (c >= MINE) && (c <= MAXE);
        if (good) begin gr[ch]++; br[ch] = 0; end
        else begin br[ch]++; gr[ch] = 0; end
        if (!mp[ch] && gr[ch] >= ACQ) mp[ch] = 1;
        else if (mp[ch] && br[ch] >= LOSS) mp[ch] = 0;
        lastc[ch] = c;
        cnt[ch] = 0;
      end else begin
        cnt[ch] = c;
      end
      hist[ch] = {hist[ch][1:0], tog[ch]};
    end
    t = (rs || t == W - 1) ? 0 : t + 1;
    chg = (oldp[0] != mp[0]) || (oldp[1] != mp[1]);
  endtask

  task automatic cycle();
    logic [1:0] tog_s;
    bit rs_s, rn_s;
    logic [6:0] act, exp;
    logic [1:0] pv;
    logic sel;
    @(posedge clk);
    tog_s = mon_toggle; rs_s = restart; rn_s = reset_n;
    if (!rn_s) model_reset(); else model_edge(tog_s, rs_s);
    #1;
    pv  = {mp[1], mp[0]};
    sel = (!mp[0] && mp[1]);
    exp = {pv, |pv, |pv, sel, chg, (t == W - 1)};
    act = {clk_present, any_present, sel_valid, sel_idx, status_change, window_end};
    check("outputs{present,any,valid,idx,chg,wend}", int'(act), int'(exp));
`ifdef CLK_MON_FREQ_REPORT_EN
    check("freq_count", int'(freq_count), int'({lastc[1][15:0], lastc[0][15:0]}));
`endif
    for (int ch = 0; ch < 2; ch++) begin
      if (per[ch] != 0) begin
        ph[ch]++;
        if (ph[ch] >= per[ch]) begin
          ph[ch] = 0;
          mon_toggle[ch] = ~mon_toggle[ch];
        end
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  task automatic wait_wend();
    for (int n = 0; n < 150; n++) begin
      cycle();
      if (window_end) break;
    end
    if (!window_end) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_wend: window_end got 0 required 1 within 150 cycles at %0t", $time);
    end
  endtask

  initial begin
    rows[0] = '{3, 0, 3, 2'b01, 1'b0};
    rows[1] = '{0, 3, 3, 2'b10, 1'b1};
    rows[2] = '{3, 3, 3, 2'b11, 1'b0};
    rows[3] = '{1, 1, 4, 2'b00, 1'b0};
    rows[4] = '{6, 6, 4, 2'b00, 1'b0};
    rows[5] = '{5, 2, 4, 2'b11, 1'b0};
    rows[6] = '{3, 0, 1, 2'b00, 1'b0};
    per[0] = 0; per[1] = 0; ph[0] = 0; ph[1] = 0;
    model_reset();

    // Reset state
    repeat (3) cycle();
    reset_n = 1'b1;

    // Table rows: restart, run N windows, check settled presence
    foreach (rows[r]) begin
      per[0] = rows[r].per0;
      per[1] = rows[r].per1;
      do_restart();
      repeat (rows[r].nwin * W + 1) cycle();
      check($sformatf("row%0d_present", r), int'(clk_present), int'(rows[r].exp_present));
      check($sformatf("row%0d_sel_idx", r), int'(sel_idx), int'(rows[r].exp_idx));
      check($sformatf("row%0d_sel_valid", r), int'(sel_valid), int'(|rows[r].exp_present));
    end

    // Loss hysteresis: one bad window holds, second drops
    per[0] = 3; per[1] = 0;
    do_restart();
    repeat (2 * W + 1) cycle();
    check("loss_acquired", int'(clk_present), 1);
    per[0] = 0;
    wait_wend(); cycle();
    check("loss_hold_one_bad", int'(clk_present), 1);
    wait_wend(); cycle();
    check("loss_dropped", int'(clk_present), 0);
    check("loss_any_present", int'(any_present), 0);
    check("loss_status_change", int'(status_change), 1);

    // Selection hands over from channel 0 to channel 1
    per[0] = 3; per[1] = 3;
    do_restart();
    repeat (2 * W + 1) cycle();
    check("handover_idx0", int'(sel_idx), 0);
    per[0] = 0;
    wait_wend(); cycle();
    wait_wend(); cycle();
    check("handover_idx1", int'(sel_idx), 1);
    check("handover_valid", int'(sel_valid), 1);

    // Alternating windows from ABSENT never acquire
    per[1] = 0;
    do_restart();
    for (int k = 0; k < 6; k++) begin
      per[0] = (k % 2 == 0) ? 3 : 0;
      wait_wend(); cycle();
      check("alt_from_absent", int'(clk_present[0]), 0);
    end
    // Alternating windows from PRESENT never drop
    per[0] = 3;
    wait_wend(); cycle();
    wait_wend(); cycle();
    check("alt_acquired", int'(clk_present[0]), 1);
    for (int k = 0; k < 6; k++) begin
      per[0] = (k % 2 == 0) ? 0 : 3;
      wait_wend(); cycle();
      check("alt_from_present", int'(clk_present[0]), 1);
    end

    // restart on the window_end cycle wins and discards that window
    per[0] = 3;
    wait_wend();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check("restart_present", int'(clk_present), 0);
    check("restart_wend", int'(window_end), 0);
    check("restart_chg", int'(status_change), 1);
    repeat (2 * W - 1) cycle();
    check("reacq_early", int'(clk_present[0]), 0);
    cycle();
    check("reacq_done", int'(clk_present[0]), 1);

    // Asynchronous reset mid-window clears outputs immediately
    repeat (37) cycle();
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({clk_present, any_present, sel_valid, sel_idx, status_change, window_end}), 0);
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;

    // Random periods per window with occasional restarts
    for (int w = 0; w < 12; w++) begin
      per[0] = $urandom_range(0, 8);
      per[1] = $urandom_range(0, 8);
      repeat (W) begin
        restart = ($urandom_range(0, 249) == 0);
        cycle();
      end
      restart = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
